// File: rtl/muldiv_sequencer_if.sv
// Handshake and HI/LO bus between the EX-stage pipeline and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             abort;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, abort, wr_hi, wr_lo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, abort, wr_hi, wr_lo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer with HI/LO; shift-add multiply and restoring divide
// over one shared carry-lookahead adder, fixed 36-cycle latency.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO writes accepted; |rs| taken here
// PREP   | |rt| taken, result signs recorded
// RUN    | 32 add-shift (mul) or trial-subtract (div) iterations
// FIX_LO | conditional negate of lo half, carry saved
// FIX_HI | conditional negate of hi half, HI/LO loaded
// DONE   | done pulse, HI/LO hold the result

module carry_lookahead_adder_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g, p, c;
  logic             carry;
  logic             gg, pg;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups chained by group generate/propagate
  always_comb begin
    c     = '0;
    carry = cin;
    gg    = 1'b0;
    pg    = 1'b0;
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = carry;
      c[4*k+1] = g[4*k] | (p[4*k] & carry);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      carry = gg | (pg & carry);
    end
  end

  assign sum  = p ^ c;
  assign cout = carry;
endmodule

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_RUN, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, acc_q, acc_d, mq_q, mq_d, hi_q, hi_d, lo_q, lo_d;
  logic             rs_neg_q, rs_neg_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic             carry_q, carry_d, dz_q, dz_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic [WIDTH-1:0] rs_abs, prep_src;
  logic             rs_neg, prep_neg, keep;

  carry_lookahead_adder_32bit #(.WIDTH(WIDTH)) u_add (
    .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rs_neg_d = rs_neg_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    carry_d  = carry_q;
    dz_d     = dz_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    rs_neg   = bus.op[0] & bus.rs_val[WIDTH-1];
    rs_abs   = bus.rs_val;
    prep_src = op_q[1] ? a_q : mq_q;
    prep_neg = op_q[0] & prep_src[WIDTH-1];
    keep     = 1'b0;

    case (state_q)
      S_IDLE: begin
        add_a   = ~bus.rs_val;
        add_cin = 1'b1;
        if (rs_neg) rs_abs = add_sum;
        if (bus.wr_hi) hi_d = bus.wr_data;
        if (bus.wr_lo) lo_d = bus.wr_data;
        if (bus.start) begin
          op_d     = bus.op;
          rs_neg_d = rs_neg;
          dz_d     = bus.op[1] & (bus.rt_val == '0);
          acc_d    = '0;
          cnt_d    = '0;
          carry_d  = 1'b0;
          // divide keeps the dividend in mq and the divisor in a
          if (bus.op[1]) begin
            mq_d = rs_abs;
            a_d  = bus.rt_val;
          end else begin
            a_d  = rs_abs;
            mq_d = bus.rt_val;
          end
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        add_a   = ~prep_src;
        add_cin = 1'b1;
        if (prep_neg) begin
          if (op_q[1]) a_d = add_sum;
          else         mq_d = add_sum;
        end
        // divide-by-zero keeps the all-ones quotient; remainder returns to rs_val
        neg_lo_d = (rs_neg_q ^ prep_neg) & ~dz_q;
        neg_hi_d = op_q[1] ? rs_neg_q : (rs_neg_q ^ prep_neg);
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (op_q[1]) begin
          add_a   = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
          add_b   = ~a_q;
          add_cin = 1'b1;
          // bit shifted out of acc makes the trial value exceed any divisor
          keep    = acc_q[WIDTH-1] | add_cout;
          acc_d   = keep ? add_sum : add_a;
          mq_d    = {mq_q[WIDTH-2:0], keep};
        end else begin
          add_a = acc_q;
          add_b = mq_q[0] ? a_q : '0;
          acc_d = {add_cout, add_sum[WIDTH-1:1]};
          mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX_LO;
      end
      S_FIX_LO: begin
        add_a   = ~mq_q;
        add_cin = 1'b1;
        if (neg_lo_q) mq_d = add_sum;
        carry_d = add_cout;
        state_d = S_FIX_HI;
      end
      S_FIX_HI: begin
        add_a   = ~acc_q;
        add_cin = op_q[1] ? 1'b1 : carry_q;
        if (!bus.abort) begin
          hi_d = neg_hi_q ? add_sum : acc_q;
          lo_d = mq_q;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      rs_neg_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      carry_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      rs_neg_q <= rs_neg_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      carry_q  <= carry_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy        = (state_q == S_PREP) || (state_q == S_RUN) ||
                           (state_q == S_FIX_LO) || (state_q == S_FIX_HI);
  assign bus.done        = (state_q == S_DONE);
  assign bus.div_by_zero = (state_q == S_DONE) & dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
